// File: rtl/slowclk_mon_pkg.sv
// Shared types and constants for the slow clock monitor.
package slowclk_mon_pkg;

    // Lock tracking states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2,
        LOST    = 2'd3
    } mon_state_t;

    // Width of the saturating error counter
    localparam int ERR_W = 8;

endpackage

// File: rtl/sync_edge_detect.sv
// Brings the asynchronous slow signal into clk, detects its edges and
// produces registered rise/fall strobes. edge_now is the combinational
// edge indication; it is high in the cycle just before the tick appears,
// so logic registering on it lines up with the ticks.
module sync_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic slow_in,
    output logic tick_rise,
    output logic tick_fall,
    output logic edge_now
);

    logic       sync_a;
    logic       sync_b;
    logic       prev;
    logic [1:0] warm;

    // Edges are ignored until the synchronizer and previous-value register
    // hold real samples, so a level present across reset never ticks.
    assign edge_now = (warm == 2'd3) && (sync_b != prev);

    // Two-flop synchronizer, previous-value register and tick strobes
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_a    <= 1'b0;
            sync_b    <= 1'b0;
            prev      <= 1'b0;
            warm      <= 2'd0;
            tick_rise <= 1'b0;
            tick_fall <= 1'b0;
        end else begin
            sync_a    <= slow_in;
            sync_b    <= sync_a;
            prev      <= sync_b;
            if (warm != 2'd3) begin
                warm <= warm + 2'd1;
            end
            tick_rise <= edge_now & sync_b;
            tick_fall <= edge_now & ~sync_b;
        end
    end

endmodule

// File: rtl/slow_clock_monitor.sv
// Slow clock monitor: turns the divided board clock into clk-domain tick
// enables, measures its half-period and tracks lock against the expected
// half-period. Define SLOWCLK_ERRCNT_EN to build the saturating error
// counter; otherwise err_count is tied to zero.
module slow_clock_monitor
    import slowclk_mon_pkg::*;
#(
    parameter int HALF_EXPECTED = 50000000,
    parameter int TOL           = 1000,
    parameter int LOCK_COUNT    = 4,
    parameter int CNT_W         = 27
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             slow_in,
    output logic             tick_rise,
    output logic             tick_fall,
    output logic [CNT_W-1:0] half_period,
    output logic             period_valid,
    output logic             locked,
    output logic             lost,
    output logic [ERR_W-1:0] err_count
);

    localparam int              STREAK_W    = $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_W:0]   HI_BOUND    = (CNT_W+1)'(HALF_EXPECTED + TOL);
    localparam logic [CNT_W:0]   LO_BOUND    = (HALF_EXPECTED > TOL) ?
                                               (CNT_W+1)'(HALF_EXPECTED - TOL) : '0;
    localparam logic [CNT_W-1:0] CNT_MAX     = CNT_W'(HALF_EXPECTED + TOL);
    localparam logic [STREAK_W-1:0] STREAK_LAST = STREAK_W'(LOCK_COUNT - 1);

    logic                edge_now;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W:0]      measured;
    logic                in_tol;
    logic                timeout;
    mon_state_t          state;
    mon_state_t          state_next;
    logic [STREAK_W-1:0] streak;
    logic [STREAK_W-1:0] streak_next;
    logic                pv_next;
    logic [CNT_W-1:0]    hp_next;
    logic                err_inc;

    sync_edge_detect u_sync (
        .clk      (clk),
        .reset    (reset),
        .slow_in  (slow_in),
        .tick_rise(tick_rise),
        .tick_fall(tick_fall),
        .edge_now (edge_now)
    );

    // cnt holds cycles since the last edge minus one, so cnt+1 is the distance
    assign measured = {1'b0, cnt} + (CNT_W+1)'(1);
    assign in_tol   = (measured >= LO_BOUND) && (measured <= HI_BOUND);
    assign timeout  = (cnt == CNT_MAX) && !edge_now;

    assign locked = (state == LOCKED);
    assign lost   = (state == LOST);

    // Edge-to-edge cycle counter, saturating at the upper tolerance bound
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (edge_now) begin
            cnt <= '0;
        end else if (cnt != CNT_MAX) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Next-state, measurement latch and error decisions; an edge beats a timeout
    always_comb begin
        state_next  = state;
        streak_next = streak;
        pv_next     = 1'b0;
        hp_next     = half_period;
        err_inc     = 1'b0;
        case (state)
            IDLE: begin
                if (edge_now) begin
                    state_next  = MEASURE;
                    streak_next = '0;
                end
            end
            MEASURE: begin
                if (edge_now) begin
                    pv_next = 1'b1;
                    hp_next = measured[CNT_W-1:0];
                    if (in_tol) begin
                        if (streak == STREAK_LAST) begin
                            state_next = LOCKED;
                        end else begin
                            streak_next = streak + STREAK_W'(1);
                        end
                    end else begin
                        streak_next = '0;
                        err_inc     = 1'b1;
                    end
                end else if (timeout) begin
                    state_next = LOST;
                    err_inc    = 1'b1;
                end
            end
            LOCKED: begin
                if (edge_now) begin
                    pv_next = 1'b1;
                    hp_next = measured[CNT_W-1:0];
                    if (!in_tol) begin
                        state_next = LOST;
                        err_inc    = 1'b1;
                    end
                end else if (timeout) begin
                    state_next = LOST;
                    err_inc    = 1'b1;
                end
            end
            LOST: begin
                // The recovering edge only restarts measurement
                if (edge_now) begin
                    state_next  = MEASURE;
                    streak_next = '0;
                end
            end
            default: begin
                state_next  = IDLE;
                streak_next = '0;
            end
        endcase
    end

    // State, streak and measurement registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            streak       <= '0;
            period_valid <= 1'b0;
            half_period  <= '0;
        end else begin
            state        <= state_next;
            streak       <= streak_next;
            period_valid <= pv_next;
            half_period  <= hp_next;
        end
    end

`ifdef SLOWCLK_ERRCNT_EN
    // Saturating count of out-of-tolerance measurements and timeouts
    always_ff @(posedge clk) begin
        if (reset) begin
            err_count <= '0;
        end else if (err_inc && (err_count != {ERR_W{1'b1}})) begin
            err_count <= err_count + ERR_W'(1);
        end
    end
`else
    logic unused_err_inc;
    assign unused_err_inc = err_inc;
    assign err_count      = '0;
`endif

endmodule

// File: tb/tb_slow_clock_monitor.sv
// Scoreboard bench for slow_clock_monitor. The reference model works on
// toggle intervals: each toggle of slow_in yields one expected tick event,
// each over-long gap in an active state yields one expected timeout event.
module tb_slow_clock_monitor;

    localparam int H      = 10;
    localparam int T      = 1;
    localparam int LC     = 4;
    localparam int CW     = 5;
    localparam int SATMAX = H + T;
`ifdef SLOWCLK_ERRCNT_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    localparam int M_IDLE = 0;
    localparam int M_MEAS = 1;
    localparam int M_LOCK = 2;
    localparam int M_LOST = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          slow_in = 1'b0;
    logic          tick_rise;
    logic          tick_fall;
    logic [CW-1:0] half_period;
    logic          period_valid;
    logic          locked;
    logic          lost;
    logic [7:0]    err_count;

    slow_clock_monitor #(
        .HALF_EXPECTED(H),
        .TOL          (T),
        .LOCK_COUNT   (LC),
        .CNT_W        (CW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .slow_in     (slow_in),
        .tick_rise   (tick_rise),
        .tick_fall   (tick_fall),
        .half_period (half_period),
        .period_valid(period_valid),
        .locked      (locked),
        .lost        (lost),
        .err_count   (err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit is_timeout;
        bit rise;
        bit pv;
        int hp;
        bit locked;
        bit lost;
        int err;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    int   m_state;
    int   m_streak;
    int   m_err;
    int   m_since;
    bit   m_level;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void bump_err();
        if (ERR_EN && m_err < 255) m_err++;
    endfunction

    // Expected outcome of one slow_in toggle arriving d cycles after the previous one
    function automatic void model_edge(input int d);
        exp_t e;
        bit   good;
        m_level      = ~m_level;
        e.is_timeout = 1'b0;
        e.rise       = m_level;
        e.pv         = 1'b0;
        e.hp         = 0;
        good         = (d >= H - T) && (d <= H + T);
        if (m_state == M_IDLE || m_state == M_LOST) begin
            m_state  = M_MEAS;
            m_streak = 0;
        end else begin
            e.pv = 1'b1;
            e.hp = d;
            if (m_state == M_MEAS) begin
                if (good) begin
                    m_streak++;
                    if (m_streak == LC) m_state = M_LOCK;
                end else begin
                    m_streak = 0;
                    bump_err();
                end
            end else if (!good) begin
                m_state = M_LOST;
                bump_err();
            end
        end
        e.locked = (m_state == M_LOCK);
        e.lost   = (m_state == M_LOST);
        e.err    = m_err;
        q.push_back(e);
    endfunction

    // Wait g cycles with no edge, then optionally toggle slow_in
    task automatic op(input bit do_toggle, input int g);
        int   d;
        exp_t e;
        d = m_since + g;
        // The counter saturates SATMAX cycles after an edge; with no edge
        // in the following cycle a timeout fires.
        if ((m_state == M_MEAS || m_state == M_LOCK) && d >= SATMAX + 2) begin
            bump_err();
            m_state      = M_LOST;
            e.is_timeout = 1'b1;
            e.rise       = 1'b0;
            e.pv         = 1'b0;
            e.hp         = 0;
            e.locked     = 1'b0;
            e.lost       = 1'b1;
            e.err        = m_err;
            q.push_back(e);
        end
        if (do_toggle) begin
            model_edge(d);
            m_since = 0;
        end else begin
            m_since = d;
        end
        repeat (g) @(posedge clk);
        #1;
        if (do_toggle) slow_in = ~slow_in;
    endtask

    task automatic do_reset(input int n, input bit lvl);
        @(posedge clk);
        #1;
        chk("queue_drained_before_reset", q.size(), 0);
        q.delete();
        reset   = 1'b1;
        slow_in = lvl;
        repeat (n) @(posedge clk);
        #1;
        reset    = 1'b0;
        m_state  = M_IDLE;
        m_streak = 0;
        m_err    = 0;
        m_since  = 0;
        m_level  = lvl;
        chk("rst_tick_rise", tick_rise, 0);
        chk("rst_tick_fall", tick_fall, 0);
        chk("rst_period_valid", period_valid, 0);
        chk("rst_half_period", half_period, 0);
        chk("rst_locked", locked, 0);
        chk("rst_lost", lost, 0);
        chk("rst_err_count", err_count, 0);
    endtask

    // Monitor: pops an expectation whenever the DUT presents an event
    logic lost_q = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (tick_rise || tick_fall) begin
                chk("tick_exclusive", tick_rise & tick_fall, 0);
                chk("tick_expected", q.size() > 0, 1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk("tick_not_timeout", 0, e.is_timeout);
                    chk("tick_dir_rise", tick_rise, e.rise);
                    chk("tick_period_valid", period_valid, e.pv);
                    if (e.pv) chk("tick_half_period", half_period, e.hp);
                    chk("tick_locked", locked, e.locked);
                    chk("tick_lost", lost, e.lost);
                    chk("tick_err_count", err_count, e.err);
                end
            end else begin
                if (period_valid) chk("pv_without_tick", period_valid, 0);
                if (lost && !lost_q) begin
                    chk("timeout_expected", q.size() > 0, 1);
                    if (q.size() > 0) begin
                        e = q.pop_front();
                        chk("timeout_kind", 1, e.is_timeout);
                        chk("timeout_locked", locked, e.locked);
                        chk("timeout_err_count", err_count, e.err);
                    end
                end
            end
        end
        lost_q <= lost;
    end

    initial begin
        int r;
        m_state  = M_IDLE;
        m_streak = 0;
        m_err    = 0;
        m_since  = 0;
        m_level  = 1'b0;

        do_reset(2, 1'b0);

        // Lock at the nominal half-period
        repeat (6) op(1'b1, 10);
        // Boundary intervals keep lock, 12 loses it
        op(1'b1, 9);
        op(1'b1, 11);
        op(1'b1, 10);
        op(1'b1, 12);
        // Recovery
        repeat (5) op(1'b1, 10);
        // Timeout from LOCKED
        op(1'b0, 20);
        repeat (6) op(1'b1, 10);

        // Reset while in MEASURE, then restart
        op(1'b0, 20);
        repeat (2) op(1'b1, 10);
        op(1'b0, 6);
        do_reset(1, slow_in);
        repeat (7) op(1'b1, 10);

        // Level held high through reset must not tick
        op(1'b0, 20);
        do_reset(3, 1'b1);
        op(1'b0, 8);
        repeat (6) op(1'b1, 10);

        // Randomized intervals
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 9);
            if (r <= 5)      op(1'b1, $urandom_range(9, 11));
            else if (r <= 7) op(1'b1, ($urandom_range(0, 1) != 0) ? 12 : 8);
            else if (r == 8) op(1'b1, $urandom_range(1, 20));
            else             op(1'b0, $urandom_range(5, 25));
        end

        op(1'b0, 20);
        repeat (10) @(posedge clk);
        #1;
        chk("queue_empty_at_end", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
